mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-port arbiter and sequencer for the single-port program/data RAM of the EduLent CPU. It shares the RAM between the CPU memory interface and a loader/DMA requester (UART loader, debug port). It serialises accesses, inserts the RAM read latency, and returns a one-cycle acknowledge to the owning requester. The control unit stalls its memory-transfer states (read into MD, write from MD) on `o_cpu_stall`.

## Interface
- `ADDR_W`, default 8: address width.
- `DATA_W`, default 8: data width.
- `RD_LAT`, default 1: RAM read latency in cycles after the enable cycle; legal range 1..4.
- `CPU_PRIO`, default 1: 1 = CPU has fixed priority; 0 = round-robin.
- `i_clk`  in  1  clock.
- `i_rstn`  in  1  asynchronous, active-low reset.
- `i_cpu_req`  in  1  CPU access request; held until ack.
- `i_cpu_we`  in  1  1 = write, 0 = read.
- `i_cpu_addr`  in  ADDR_W  CPU address.
- `i_cpu_wdata`  in  DATA_W  CPU write data.
- `o_cpu_rdata`  out  DATA_W  last CPU read data; registered.
- `o_cpu_ack`  out  1  one-cycle completion pulse.
- `o_cpu_stall`  out  1  combinational: `i_cpu_req & ~o_cpu_ack`.
- `i_ld_req`, `i_ld_we`, `i_ld_addr`, `i_ld_wdata`, `o_ld_rdata`, `o_ld_ack`: loader port; same directions, widths and meanings as the CPU signals.
- `o_mem_en`  out  1  RAM enable.
- `o_mem_we`  out  1  RAM write enable.
- `o_mem_addr`  out  ADDR_W  RAM address.
- `o_mem_wdata`  out  DATA_W  RAM write data.
- `i_mem_rdata`  in  DATA_W  RAM read data, valid `RD_LAT` cycles after the enable cycle.

## Operation
- FSM states: `IDLE`, `ISSUE`, `WAIT`, `DONE`.
- **IDLE**
  - If any request is high, select the winner.
  - Latch into `owner`: owner, we, addr, wdata.
  - Go to `ISSUE`.
  - If no request is high, stay in `IDLE`.
- **ISSUE**
  - `o_mem_en`=1 for exactly one cycle; `o_mem_we`, `o_mem_addr`, `o_mem_wdata` come from the latched values.
  - Write: go to `DONE`.
  - Read: go to `WAIT` and load the latency counter with `RD_LAT-1`.
- **WAIT**
  - Lasts exactly `RD_LAT` cycles.
  - On the last cycle (counter==0), sample `i_mem_rdata` into the owner's rdata register, then go to `DONE`.
- **DONE**
  - The owner's ack is 1 for this cycle only.
  - Update `last_owner`.
  - Go to `IDLE`.
- **Arbitration**
  - `CPU_PRIO`=1: CPU wins any tie.
  - `CPU_PRIO`=0: on a tie, grant the requester that is not `last_owner`; a single requester always wins.
- **Requester protocol**
  - Hold req, we, addr and wdata stable until ack.
  - A req still high in the cycle after ack counts as a new request.
- Read data registers change only on reads by their own owner. Writes never change them.
- Outputs in all states other than `ISSUE`: `o_mem_en`=0, `o_mem_we`=0; `o_mem_addr`/`o_mem_wdata` hold the latched values.

## Timing
- **Reset values**
  - Every output is 0 (`o_cpu_stall` follows `i_cpu_req`).
  - FSM in `IDLE`.
  - Latched fields and rdata registers are 0.
  - `last_owner` = loader, so the CPU wins the first round-robin tie.
- **Latency** (request sampled in `IDLE` at cycle 0):
  - Write: enable at cycle 1, ack at cycle 2.
  - Read: enable at cycle 1, data sampled at cycle 1+`RD_LAT`, ack at cycle 2+`RD_LAT`.
  - `o_*_rdata` is valid in the ack cycle and held afterwards.
- Back-to-back throughput: one write per 3 cycles; one read per 3+`RD_LAT` cycles.
- **Simultaneous events**
  - A request arriving during a transaction waits; it is never dropped.
  - Arbitration happens only in `IDLE`.
- **Protocol violation:** req dropped mid-transaction → the transaction still completes and ack still pulses.
- **Reset mid-operation:** return to `IDLE` immediately with no ack. A write already issued in `ISSUE` is not undone.

## Structure
- Shared package `edulent_pkg`:
  - `arb_state_t` enum: `IDLE`, `ISSUE`, `WAIT`, `DONE`.
  - `owner_t` enum: `OWN_CPU`=0, `OWN_LD`=1.
- Latency counter width: `$clog2(RD_LAT+1)`.
- Single module; no sub-module. Winner selection is a small `always_comb` block.

## Test plan
- Reset: assert `i_rstn`=0 mid-read → all acks 0, `o_mem_en`=0, FSM in `IDLE`, rdata registers 0.
- CPU write: addr 0x10, data 0xA5 → `o_mem_en`/`o_mem_we`=1 with 0x10/0xA5 at cycle 1, `o_cpu_ack` at cycle 2.
- CPU read of 0x10 with `RD_LAT`=2 (RAM returns 0xA5) → ack at cycle 4, `o_cpu_rdata`=0xA5; `o_ld_rdata` unchanged.
- Tie, `CPU_PRIO`=1: both request on the same cycle → CPU served first, loader ack 3 cycles after CPU ack (writes).
- Tie, `CPU_PRIO`=0: both requesters hold req for 4 transactions → grants alternate CPU, LD, CPU, LD.
- Stall: CPU req held while loader owns the port → `o_cpu_stall`=1 until the `o_cpu_ack` cycle, then 0.

Source files
------------

// File: rtl/edulent_pkg.sv
// Shared EduLent types: arbiter FSM states and memory-port owner encoding.
package edulent_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-port program/data RAM between the CPU and the loader/DMA
// port: arbitrates in IDLE, issues one RAM access, waits the read latency, acks.
module mem_port_arbiter
    import edulent_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int CPU_PRIO = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ack,
    output logic              o_cpu_stall,
    input  logic              i_ld_req,
    input  logic              i_ld_we,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_wdata,
    output logic [DATA_W-1:0] o_ld_rdata,
    output logic              o_ld_ack,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    arb_state_t        state_r;
    owner_t            owner_r;
    owner_t            last_owner_r;
    owner_t            winner_s;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              mem_en_r;
    logic              mem_we_r;
    logic              cpu_ack_r;
    logic              ld_ack_r;
    logic [DATA_W-1:0] cpu_rdata_r;
    logic [DATA_W-1:0] ld_rdata_r;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    // Winner selection: on a round-robin tie the port that did not go last wins.
    always_comb begin
        winner_s = OWN_CPU;
        if (i_cpu_req && i_ld_req) begin
            if (CPU_PRIO != 0) begin
                winner_s = OWN_CPU;
            end else if (last_owner_r == OWN_CPU) begin
                winner_s = OWN_LD;
            end else begin
                winner_s = OWN_CPU;
            end
        end else if (i_ld_req) begin
            winner_s = OWN_LD;
        end else begin
            winner_s = OWN_CPU;
        end
    end

    // Request fields of the selected winner, to be latched on grant.
    always_comb begin
        sel_we_s    = i_cpu_we;
        sel_addr_s  = i_cpu_addr;
        sel_wdata_s = i_cpu_wdata;
        if (winner_s == OWN_LD) begin
            sel_we_s    = i_ld_we;
            sel_addr_s  = i_ld_addr;
            sel_wdata_s = i_ld_wdata;
        end else begin
            sel_we_s    = i_cpu_we;
            sel_addr_s  = i_cpu_addr;
            sel_wdata_s = i_cpu_wdata;
        end
    end

    // Sequencer FSM; RAM strobes and acks are registered on entry to ISSUE/DONE.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r      <= IDLE;
            owner_r      <= OWN_CPU;
            last_owner_r <= OWN_LD;
            we_r         <= 1'b0;
            addr_r       <= {ADDR_W{1'b0}};
            wdata_r      <= {DATA_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            mem_en_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            cpu_ack_r    <= 1'b0;
            ld_ack_r     <= 1'b0;
            cpu_rdata_r  <= {DATA_W{1'b0}};
            ld_rdata_r   <= {DATA_W{1'b0}};
        end else begin
            mem_en_r  <= 1'b0;
            mem_we_r  <= 1'b0;
            cpu_ack_r <= 1'b0;
            ld_ack_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_cpu_req || i_ld_req) begin
                        owner_r  <= winner_s;
                        we_r     <= sel_we_s;
                        addr_r   <= sel_addr_s;
                        wdata_r  <= sel_wdata_s;
                        mem_en_r <= 1'b1;
                        mem_we_r <= sel_we_s;
                        state_r  <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    if (we_r) begin
                        cpu_ack_r <= (owner_r == OWN_CPU);
                        ld_ack_r  <= (owner_r == OWN_LD);
                        state_r   <= DONE;
                    end else begin
                        cnt_r   <= CNT_W'(RD_LAT - 1);
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        if (owner_r == OWN_LD) begin
                            ld_rdata_r <= i_mem_rdata;
                        end else begin
                            cpu_rdata_r <= i_mem_rdata;
                        end
                        cpu_ack_r <= (owner_r == OWN_CPU);
                        ld_ack_r  <= (owner_r == OWN_LD);
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                DONE: begin
                    last_owner_r <= owner_r;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign o_mem_en    = mem_en_r;
    assign o_mem_we    = mem_we_r;
    assign o_mem_addr  = addr_r;
    assign o_mem_wdata = wdata_r;
    assign o_cpu_ack   = cpu_ack_r;
    assign o_ld_ack    = ld_ack_r;
    assign o_cpu_rdata = cpu_rdata_r;
    assign o_ld_rdata  = ld_rdata_r;
    assign o_cpu_stall = i_cpu_req & ~cpu_ack_r;

endmodule
